seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//  Time-multiplexed scan scheduler for the shared 8-digit 7-segment display.
//  Shares HEX/DP among DIGITS anodes, one digit slot at a time, with a blanking guard between slots.
//  Takes frame updates over a valid/ready handshake and applies them only at frame start, so a frame never tears.
//  Sits between the lab datapath (values/masks) and the board pins HEX/DP/AN.
// PARAMETERS
//  DIGITS  8      number of digits/anodes (2..8)
//  DIV     100000 clocks per digit slot (>=2)
//  BLANK   1000   clocks at end of each slot with all anodes off (1..DIV-1)
// PORTS
//  clk         in   1          system clock, rising edge
//  reset       in   1          asynchronous, active-low reset
//  load_valid  in   1          new frame offered on data_in/en_in/dp_in
//  load_ready  out  1          controller can accept a frame
//  data_in     in   4*DIGITS   nibble per digit, digit i = data_in[4i+3:4i]
//  en_in       in   DIGITS     1 = digit i lit, 0 = digit i dark
//  dp_in       in   DIGITS     1 = decimal point of digit i lit
//  frame_start out  1          1-cycle pulse when a frame begins (digit 0 enters SHOW)
//  HEX         out  7          segments, active-low, HEX[0]=a ... HEX[6]=g
//  DP          out  1          decimal point, active-low
//  AN          out  DIGITS     anodes, active-low, AN[i] selects digit i
// BEHAVIOUR
//  Reset (reset=0, async)
//   - AN all 1, HEX=7'h7F, DP=1, frame_start=0, load_ready=1.
//   - digit=0, cnt=0, shadow data/en/dp=0, pending empty.
//  Slot counter
//   - cnt runs 0..DIV-1, then wraps to 0 and digit advances.
//   - digit wraps from DIGITS-1 to 0.
//  Slot states, decoded from cnt
//   - SHOW: cnt < DIV-BLANK.
//   - BLANK: otherwise.
//  Outputs
//   - Registered: each output reflects (digit, cnt, shadow) one clock later.
//  During SHOW
//   - AN[digit]=~en_sh[digit]; all other AN bits are 1.
//   - HEX=~seg(data_sh[digit]).
//   - DP=~(dp_sh[digit] & en_sh[digit]).
//  During BLANK
//   - AN all 1, HEX=7'h7F, DP=1.
//  Disabled digit
//   - Still consumes its full slot; its AN bit stays 1.
//  seg(): active-high a..g for the standard hex glyphs
//   - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
//   - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
//  Handshake
//   - Accept on the edge where load_valid & load_ready; capture into the pending regs; pending becomes full.
//   - load_ready = ~pending_full. Upstream must hold data while valid & ~ready.
//  Frame boundary
//   - The edge where cnt wraps to 0 and digit wraps to 0.
//   - If pending_full at that edge: shadow<=pending and pending_full<=0, so load_ready=1 next cycle.
//   - The first SHOW cycle of the new frame shows the new data.
//   - frame_start is registered and pulses in the first cycle of every frame, whether or not an update occurred.
//  Simultaneous events
//   - Accept in the same cycle as a boundary is impossible while pending is full (ready=0).
//   - With pending empty, a frame accepted on the boundary edge is applied at the next boundary, not this one.
//  Reset mid-operation
//   - Immediate blank, pending discarded, scan restarts at digit 0, cnt 0.
//  Widths
//   - cnt is $clog2(DIV) bits; digit is $clog2(DIGITS) bits (min 1).
//   - No arithmetic beyond the counters; the counters never overflow past DIV-1 / DIGITS-1.
// TESTING  (DIGITS=8, DIV=4, BLANK=1)
//  1. Reset held, then released
//     - AN=8'hFF, HEX=7'h7F, DP=1, load_ready=1.
//     - After release, every slot is dark because shadow en=0.
//  2. Load data_in=32'h76543210, en_in=8'hFF, dp_in=8'h01
//     - Applied at the next boundary, then AN steps FE,FD,...,7F.
//     - Each digit is shown for 3 cycles with a 1-cycle FF gap.
//     - HEX during AN=FE is 7'h40 with DP=0; HEX during AN=FD is 7'h79 with DP=1.
//  3. Load en_in=8'h05
//     - Only AN=FE and AN=FB ever go active.
//     - Slots 1 and 3..7 stay FF for their full 4 cycles; the frame is still 32 cycles long.
//  4. Hold load_valid=1 with two different frames mid-frame
//     - The first frame is accepted; load_ready=0 until the boundary.
//     - The second frame is accepted the cycle after; it is never visible before the following frame_start.
//  5. Assert load_valid exactly on the boundary edge with pending empty
//     - The current frame keeps the old data.
//     - The new data appears only after the next frame_start.
//  6. Pull reset low mid-slot on digit 5 with a pending frame
//     - Outputs blank asynchronously; pending is lost.
//     - After release, frame_start appears after 32 cycles.

Source files
------------

// File: rtl/seg7_scan_ctrl_if.sv
// Frame-load handshake plus the multiplexed display pins of the scan controller.
// The upstream datapath uses master; the controller uses slave.
interface seg7_scan_ctrl_if #(
    parameter int unsigned DIGITS = 8
);
    logic                load_valid;
    logic                load_ready;
    logic [4*DIGITS-1:0] data_in;
    logic [DIGITS-1:0]   en_in;
    logic [DIGITS-1:0]   dp_in;
    logic                frame_start;
    logic [6:0]          HEX;
    logic                DP;
    logic [DIGITS-1:0]   AN;

    modport master (
        output load_valid, data_in, en_in, dp_in,
        input  load_ready, frame_start, HEX, DP, AN
    );

    modport slave (
        input  load_valid, data_in, en_in, dp_in,
        output load_ready, frame_start, HEX, DP, AN
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan scheduler for a shared multi-digit 7-segment display.
// Frames wait in a pending buffer and reach the shadow copy only at frame start, so nothing tears.
module seg7_scan_ctrl #(
    parameter int unsigned DIGITS = 8,
    parameter int unsigned DIV    = 100000,
    parameter int unsigned BLANK  = 1000
) (
    input logic             clk,
    input logic             reset,
    seg7_scan_ctrl_if.slave bus
);
    localparam int unsigned CW = $clog2(DIV);
    localparam int unsigned DW = (DIGITS > 2) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] SHOW_END = CW'(DIV - BLANK);
    localparam logic [DW-1:0] DIG_LAST = DW'(DIGITS - 1);

    localparam logic SLOT_SHOW  = 1'b0;
    localparam logic SLOT_BLANK = 1'b1;

    // Slot counter and digit pointer
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] digit_q, digit_d;
    logic          cnt_wrap;
    logic          frame_wrap;
    logic          slot;

    always_comb begin
        cnt_wrap   = (cnt_q == CNT_LAST);
        frame_wrap = cnt_wrap && (digit_q == DIG_LAST);
        cnt_d      = cnt_wrap ? '0 : cnt_q + CW'(1);
        digit_d    = digit_q;
        if (cnt_wrap) begin
            digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + DW'(1);
        end
        slot = (cnt_q < SHOW_END) ? SLOT_SHOW : SLOT_BLANK;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            digit_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
        end
    end

    // Pending and shadow frame buffers
    logic [4*DIGITS-1:0] pend_data_q, sh_data_q;
    logic [DIGITS-1:0]   pend_en_q, pend_dp_q;
    logic [DIGITS-1:0]   sh_en_q, sh_dp_q;
    logic                pend_full_q;
    logic                accept;
    logic                promote;

    assign accept         = bus.load_valid & ~pend_full_q;
    assign promote        = frame_wrap & pend_full_q;
    assign bus.load_ready = ~pend_full_q;

    // A frame accepted on the boundary edge itself waits a full frame: promote needs pend_full_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_data_q <= '0;
            pend_en_q   <= '0;
            pend_dp_q   <= '0;
            pend_full_q <= 1'b0;
            sh_data_q   <= '0;
            sh_en_q     <= '0;
            sh_dp_q     <= '0;
        end else if (promote) begin
            sh_data_q   <= pend_data_q;
            sh_en_q     <= pend_en_q;
            sh_dp_q     <= pend_dp_q;
            pend_full_q <= 1'b0;
        end else if (accept) begin
            pend_data_q <= bus.data_in;
            pend_en_q   <= bus.en_in;
            pend_dp_q   <= bus.dp_in;
            pend_full_q <= 1'b1;
        end
    end

    // Glyph lookup for the digit currently owning the slot
    logic [3:0] nib;
    logic       en_cur;
    logic       dp_cur;
    logic [6:0] seg_on;

    always_comb begin
        nib    = sh_data_q[{digit_q, 2'b00} +: 4];
        en_cur = sh_en_q[digit_q];
        dp_cur = sh_dp_q[digit_q];
        seg_on = 7'h00;
        unique case (nib)
            4'h0: seg_on = 7'h3F;
            4'h1: seg_on = 7'h06;
            4'h2: seg_on = 7'h5B;
            4'h3: seg_on = 7'h4F;
            4'h4: seg_on = 7'h66;
            4'h5: seg_on = 7'h6D;
            4'h6: seg_on = 7'h7D;
            4'h7: seg_on = 7'h07;
            4'h8: seg_on = 7'h7F;
            4'h9: seg_on = 7'h6F;
            4'hA: seg_on = 7'h77;
            4'hB: seg_on = 7'h7C;
            4'hC: seg_on = 7'h39;
            4'hD: seg_on = 7'h5E;
            4'hE: seg_on = 7'h79;
            4'hF: seg_on = 7'h71;
        endcase
    end

    // Registered pin drivers; a disabled digit keeps its anode off but still uses its slot.
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        hex_q, hex_d;
    logic              dp_q, dp_d;
    logic              fs_q;

    always_comb begin
        an_d  = '1;
        hex_d = 7'h7F;
        dp_d  = 1'b1;
        if (slot == SLOT_SHOW) begin
            an_d[digit_q] = ~en_cur;
            hex_d         = ~seg_on;
            dp_d          = ~(dp_cur & en_cur);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an_q  <= '1;
            hex_q <= 7'h7F;
            dp_q  <= 1'b1;
            fs_q  <= 1'b0;
        end else begin
            an_q  <= an_d;
            hex_q <= hex_d;
            dp_q  <= dp_d;
            fs_q  <= frame_wrap;
        end
    end

    assign bus.AN          = an_q;
    assign bus.HEX         = hex_q;
    assign bus.DP          = dp_q;
    assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: vector table, corner sequences and random frames vs a cycle-index model.
module tb_seg7_scan_ctrl;
    localparam int DIGITS = 8;
    localparam int DIV    = 4;
    localparam int BLANK  = 1;
    localparam int FRAME  = DIGITS * DIV;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    seg7_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

    seg7_scan_ctrl #(
        .DIGITS(DIGITS),
        .DIV   (DIV),
        .BLANK (BLANK)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  en;
        logic [7:0]  dp;
    } frame_t;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  en;
        logic [7:0]  dp;
        int          dg;
        logic [7:0]  an;
        logic [6:0]  hex;
        logic        dpo;
    } vec_t;

    logic [6:0] glyph [16];
    vec_t       tbl [7];

    frame_t m_sh;
    frame_t m_pend;
    bit     m_pfull;
    int     k;
    bit     last_acc;
    int     checks;
    int     failures;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s k=%0d got=%h want=%h", name, k, act, want);
        end
    endtask

    // Expected pins for scan position s (cycles since reset release) with frame f displayed.
    function automatic void expect_out(input int s, input frame_t f, output logic [7:0] an,
                                       output logic [6:0] hex, output logic dp);
        int         pos;
        int         dg;
        logic [3:0] n;
        pos = s % DIV;
        dg  = (s / DIV) % DIGITS;
        an  = 8'hFF;
        hex = 7'h7F;
        dp  = 1'b1;
        if (pos < DIV - BLANK) begin
            n       = f.data[4*dg +: 4];
            an[dg]  = ~f.en[dg];
            hex     = ~glyph[n];
            dp      = ~(f.dp[dg] & f.en[dg]);
        end
    endfunction

    // One clock: check ready before the edge, outputs after it, then advance the model.
    task automatic step();
        logic [7:0] ean;
        logic [6:0] ehex;
        logic       edp;
        bit         acc;
        frame_t     in;
        chk("load_ready", 32'(bus.load_ready), 32'(!m_pfull));
        acc     = bus.load_valid && !m_pfull;
        in.data = bus.data_in;
        in.en   = bus.en_in;
        in.dp   = bus.dp_in;
        @(posedge clk);
        #1;
        k++;
        expect_out(k - 1, m_sh, ean, ehex, edp);
        chk("AN", 32'(bus.AN), 32'(ean));
        chk("HEX", 32'(bus.HEX), 32'(ehex));
        chk("DP", 32'(bus.DP), 32'(edp));
        chk("frame_start", 32'(bus.frame_start), 32'((k % FRAME) == 0));
        if ((k % FRAME) == 0 && m_pfull) begin
            m_sh    = m_pend;
            m_pfull = 1'b0;
        end else if (acc) begin
            m_pend  = in;
            m_pfull = 1'b1;
        end
        last_acc = acc;
    endtask

    task automatic load_frame(input logic [31:0] d, input logic [7:0] e, input logic [7:0] p);
        bit got;
        got            = 1'b0;
        bus.data_in    = d;
        bus.en_in      = e;
        bus.dp_in      = p;
        bus.load_valid = 1'b1;
        for (int n = 0; n < 80; n++) begin
            step();
            if (last_acc) begin
                got = 1'b1;
                break;
            end
        end
        bus.load_valid = 1'b0;
        chk("load_accept", 32'(got), 32'd1);
    endtask

    task automatic wait_boundary();
        bit got;
        got = 1'b0;
        for (int n = 0; n < 80; n++) begin
            step();
            if ((k % FRAME) == 0) begin
                got = 1'b1;
                break;
            end
        end
        chk("boundary_timeout", 32'(got), 32'd1);
    endtask

    task automatic step_until_phase(input int ph);
        for (int n = 0; n < 80; n++) begin
            if ((k % FRAME) == ph) break;
            step();
        end
    endtask

    initial begin
        int  lit;
        int  odd;
        int  n;
        bit  got;

        checks         = 0;
        failures       = 0;
        k              = 0;
        last_acc       = 1'b0;
        m_sh           = '0;
        m_pend         = '0;
        m_pfull        = 1'b0;
        bus.load_valid = 1'b0;
        bus.data_in    = '0;
        bus.en_in      = '0;
        bus.dp_in      = '0;
        glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

        tbl[0] = '{32'h76543210, 8'hFF, 8'h01, 0, 8'hFE, 7'h40, 1'b0};
        tbl[1] = '{32'h76543210, 8'hFF, 8'h01, 1, 8'hFD, 7'h79, 1'b1};
        tbl[2] = '{32'h76543210, 8'h05, 8'h01, 2, 8'hFB, 7'h24, 1'b1};
        tbl[3] = '{32'h76543210, 8'h05, 8'h01, 3, 8'hFF, 7'h30, 1'b1};
        tbl[4] = '{32'hFEDCBA98, 8'h80, 8'h80, 7, 8'h7F, 7'h0E, 1'b0};
        tbl[5] = '{32'hFEDCBA98, 8'h7F, 8'h80, 7, 8'hFF, 7'h0E, 1'b1};
        tbl[6] = '{32'h0000B000, 8'h08, 8'h00, 3, 8'hF7, 7'h03, 1'b1};

        // Reset held
        repeat (3) @(posedge clk);
        #1;
        chk("rst_AN", 32'(bus.AN), 32'hFF);
        chk("rst_HEX", 32'(bus.HEX), 32'h7F);
        chk("rst_DP", 32'(bus.DP), 32'd1);
        chk("rst_ready", 32'(bus.load_ready), 32'd1);
        chk("rst_fs", 32'(bus.frame_start), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Dark first frame, then the vector table
        repeat (FRAME) step();
        for (int i = 0; i < 7; i++) begin
            load_frame(tbl[i].data, tbl[i].en, tbl[i].dp);
            wait_boundary();
            repeat (DIV * tbl[i].dg + 1) step();
            chk($sformatf("vec%0d_AN", i), 32'(bus.AN), 32'(tbl[i].an));
            chk($sformatf("vec%0d_HEX", i), 32'(bus.HEX), 32'(tbl[i].hex));
            chk($sformatf("vec%0d_DP", i), 32'(bus.DP), 32'(tbl[i].dpo));
        end

        // Sparse enable: only digits 0 and 2 light, frame length unchanged
        load_frame(32'h76543210, 8'h05, 8'h00);
        wait_boundary();
        lit = 0;
        odd = 0;
        for (int c = 0; c < FRAME; c++) begin
            step();
            if (bus.AN != 8'hFF) lit++;
            if (bus.AN != 8'hFF && bus.AN != 8'hFE && bus.AN != 8'hFB) odd++;
        end
        chk("sparse_lit_cycles", 32'(lit), 32'd6);
        chk("sparse_bad_anode", 32'(odd), 32'd0);

        // Two frames offered back to back mid-frame
        step_until_phase(5);
        load_frame(32'hAAAAAAAA, 8'hFF, 8'h00);
        chk("held_ready_low", 32'(bus.load_ready), 32'd0);
        bus.data_in    = 32'h55555555;
        bus.load_valid = 1'b1;
        got            = 1'b0;
        for (int c = 0; c < 80; c++) begin
            step();
            if (last_acc) begin
                got = 1'b1;
                break;
            end
        end
        bus.load_valid = 1'b0;
        chk("second_accept", 32'(got), 32'd1);
        chk("second_accept_phase", 32'(k % FRAME), 32'd1);
        chk("first_frame_shown", 32'(bus.HEX), 32'h08);
        wait_boundary();
        step();
        chk("second_frame_shown", 32'(bus.HEX), 32'h12);

        // Offer exactly on the boundary edge with pending empty
        step_until_phase(FRAME - 1);
        bus.data_in    = 32'h33333333;
        bus.en_in      = 8'hFF;
        bus.dp_in      = 8'hFF;
        bus.load_valid = 1'b1;
        step();
        bus.load_valid = 1'b0;
        chk("edge_accept", 32'(last_acc), 32'd1);
        step();
        chk("edge_old_data", 32'(bus.HEX), 32'h12);
        wait_boundary();
        step();
        chk("edge_new_data", 32'(bus.HEX), 32'h30);
        chk("edge_new_dp", 32'(bus.DP), 32'd0);

        // Reset mid-slot on digit 5 with a frame pending
        load_frame(32'h88888888, 8'hFF, 8'h00);
        step_until_phase(21);
        chk("pre_rst_AN", 32'(bus.AN), 32'hDF);
        #2;
        reset = 1'b0;
        #1;
        chk("async_AN", 32'(bus.AN), 32'hFF);
        chk("async_HEX", 32'(bus.HEX), 32'h7F);
        chk("async_DP", 32'(bus.DP), 32'd1);
        chk("async_ready", 32'(bus.load_ready), 32'd1);
        chk("async_fs", 32'(bus.frame_start), 32'd0);
        m_sh    = '0;
        m_pfull = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        k     = 0;
        n     = 0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (bus.frame_start) begin
                n = c;
                break;
            end
        end
        chk("rst_fs_latency", 32'(n), 32'd32);

        // Random frames with upstream holding data while stalled
        for (int c = 0; c < 800; c++) begin
            if (!bus.load_valid || last_acc) begin
                bus.load_valid = ($urandom_range(0, 3) == 0);
                bus.data_in    = $urandom;
                bus.en_in      = 8'($urandom);
                bus.dp_in      = 8'($urandom);
            end
            step();
        end
        bus.load_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
